// File: rtl/axi_wr_arb_2x512_pkg.sv
// Shared definitions for the two-port 512-bit AXI write arbiter:
// FSM encoding, AXI channel widths and the fixed AXI attribute values.
package axi_wr_arb_2x512_pkg;

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ID_W    = 6;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned OUTST_W = 4;

  // 64-byte beats, incrementing bursts
  localparam logic [SIZE_W-1:0]  AXI_SIZE_64B   = 3'b110;
  localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [ID_W-1:0] DEF_ID0 = 6'h00;
  localparam logic [ID_W-1:0] DEF_ID1 = 6'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_wr_arb_2x512_if.sv
// Boundary bundle of the write arbiter: two simple write client ports
// (s0_*, s1_*) and the shared AXI write master (AW/W/B).
// The master modport is the arbiter's view; slave is the surrounding system.
interface axi_wr_arb_2x512_if;
  import axi_wr_arb_2x512_pkg::*;

  logic                 s0_aw_valid, s0_aw_ready;
  logic [ADDR_W-1:0]    s0_aw_addr;
  logic                 s0_w_valid, s0_w_last, s0_w_ready;
  logic [DATA_W-1:0]    s0_w_data;
  logic                 s0_b_valid, s0_b_ready;

  logic                 s1_aw_valid, s1_aw_ready;
  logic [ADDR_W-1:0]    s1_aw_addr;
  logic                 s1_w_valid, s1_w_last, s1_w_ready;
  logic [DATA_W-1:0]    s1_w_data;
  logic                 s1_b_valid, s1_b_ready;

  logic [ID_W-1:0]      awid;
  logic [ADDR_W:0]      awaddr;
  logic [LEN_W-1:0]     awlen;
  logic [SIZE_W-1:0]    awsize;
  logic [BURST_W-1:0]   awburst;
  logic                 awlock, awvalid, awready;
  logic [DATA_W-1:0]    wdata;
  logic [STRB_W-1:0]    wstrb;
  logic                 wlast, wvalid, wready;
  logic [ID_W-1:0]      bid;
  logic                 bvalid, bready;

  modport master (
    input  s0_aw_valid, s0_aw_addr, s0_w_valid, s0_w_last, s0_w_data, s0_b_ready,
    output s0_aw_ready, s0_w_ready, s0_b_valid,
    input  s1_aw_valid, s1_aw_addr, s1_w_valid, s1_w_last, s1_w_data, s1_b_ready,
    output s1_aw_ready, s1_w_ready, s1_b_valid,
    output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bvalid,
    output bready
  );

  modport slave (
    output s0_aw_valid, s0_aw_addr, s0_w_valid, s0_w_last, s0_w_data, s0_b_ready,
    input  s0_aw_ready, s0_w_ready, s0_b_valid,
    output s1_aw_valid, s1_aw_addr, s1_w_valid, s1_w_last, s1_w_data, s1_b_ready,
    input  s1_aw_ready, s1_w_ready, s1_b_valid,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_wr_arb_2x512_wr_outst_cnt.sv
// Per-port count of bursts granted but not yet answered on B.
// Saturates at MAX_OUTST and at zero; simultaneous inc/dec cancel.
module axi_wr_arb_2x512_wr_outst_cnt
  import axi_wr_arb_2x512_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic axi_clk,
  input  logic axi_rstn,
  input  logic inc,
  input  logic dec,
  output logic at_limit
);

  localparam logic [OUTST_W-1:0] MAX_V = OUTST_W'(MAX_OUTST);

  logic [OUTST_W-1:0] cnt_q;

  // up/down count of un-responded bursts
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt_q <= '0;
    end else if (inc && !dec && (cnt_q != MAX_V)) begin
      cnt_q <= cnt_q + OUTST_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_q <= cnt_q - OUTST_W'(1);
    end
  end

  assign at_limit = (cnt_q >= MAX_V);

endmodule

// File: rtl/axi_wr_arb_2x512.sv
// Two-port AXI write arbiter: round-robin grant of fixed-length 512-bit
// bursts onto one AXI master, one burst in AW/W at a time, B responses
// routed back by ID, per-port cap on outstanding bursts.
module axi_wr_arb_2x512
  import axi_wr_arb_2x512_pkg::*;
#(
  parameter int unsigned     BURST_LEN = 32,
  parameter int unsigned     MAX_OUTST = 4,
  parameter logic [ID_W-1:0] ID0       = DEF_ID0,
  parameter logic [ID_W-1:0] ID1       = DEF_ID1
) (
  input  logic                   axi_clk,
  input  logic                   axi_rstn,
  axi_wr_arb_2x512_if.master     bus,
  output logic                   err_last,
  output logic                   err_bid
);

  localparam int unsigned      CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  wr_state_e          state_q;
  logic               grant_q;
  logic               prio_q;
  logic [CNT_W-1:0]   beat_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               full0, full1;
  logic               elig0, elig1, pick1, aw_go;
  logic               aw_rdy0, aw_rdy1;
  logic               in_data, g_w_valid, g_w_last, w_hs, last_beat;
  logic               b_sel0, b_sel1, b_hs0, b_hs1, b_unknown;

  // eligibility and round-robin pick; grant only while idle and out of reset
  always_comb begin
    elig0   = bus.s0_aw_valid && !full0;
    elig1   = bus.s1_aw_valid && !full1;
    pick1   = prio_q ? elig1 : !elig0;
    aw_go   = axi_rstn && (state_q == ST_IDLE) && (elig0 || elig1);
    aw_rdy0 = aw_go && !pick1;
    aw_rdy1 = aw_go && pick1;
  end

  assign bus.s0_aw_ready = aw_rdy0;
  assign bus.s1_aw_ready = aw_rdy1;

  // AW channel: constants plus the registered address of the granted port
  assign bus.awvalid = (state_q == ST_ADDR);
  assign bus.awaddr  = {1'b0, addr_q};
  assign bus.awid    = grant_q ? ID1 : ID0;
  assign bus.awlen   = LEN_W'(BURST_LEN - 1);
  assign bus.awsize  = AXI_SIZE_64B;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = 1'b0;

  // W channel: pass-through of the granted port, wlast from our own count
  assign in_data        = (state_q == ST_DATA);
  assign g_w_valid      = grant_q ? bus.s1_w_valid : bus.s0_w_valid;
  assign g_w_last       = grant_q ? bus.s1_w_last  : bus.s0_w_last;
  assign last_beat      = (beat_q == LAST_BEAT);
  assign bus.wvalid     = in_data && g_w_valid;
  assign bus.wdata      = grant_q ? bus.s1_w_data : bus.s0_w_data;
  assign bus.wstrb      = '1;
  assign bus.wlast      = in_data && last_beat;
  assign bus.s0_w_ready = in_data && !grant_q && bus.wready;
  assign bus.s1_w_ready = in_data && grant_q && bus.wready;
  assign w_hs           = bus.wvalid && bus.wready;

  // B channel: routed purely by ID; unknown IDs are drained here
  assign b_sel0         = (bus.bid == ID0);
  assign b_sel1         = !b_sel0 && (bus.bid == ID1);
  assign bus.s0_b_valid = bus.bvalid && b_sel0;
  assign bus.s1_b_valid = bus.bvalid && b_sel1;
  assign bus.bready     = b_sel0 ? bus.s0_b_ready : (b_sel1 ? bus.s1_b_ready : 1'b1);
  assign b_hs0          = bus.bvalid && b_sel0 && bus.s0_b_ready;
  assign b_hs1          = bus.bvalid && b_sel1 && bus.s1_b_ready;
  assign b_unknown      = bus.bvalid && !b_sel0 && !b_sel1;

  // burst sequencer: IDLE -> ADDR -> DATA -> IDLE
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aw_go) begin
            grant_q <= pick1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.awready) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_q  <= '0;
              prio_q  <= !grant_q;
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // capture the granted burst address on the client AW handshake
  always_ff @(posedge axi_clk) begin
    if (aw_go) begin
      addr_q <= pick1 ? bus.s1_aw_addr : bus.s0_aw_addr;
    end
  end

  // sticky protocol error flags
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      err_last <= 1'b0;
      err_bid  <= 1'b0;
    end else begin
      if (w_hs && (g_w_last != last_beat)) begin
        err_last <= 1'b1;
      end
      if (b_unknown) begin
        err_bid <= 1'b1;
      end
    end
  end

  axi_wr_arb_2x512_wr_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst0 (
    .axi_clk  (axi_clk),
    .axi_rstn (axi_rstn),
    .inc      (aw_rdy0),
    .dec      (b_hs0),
    .at_limit (full0)
  );

  axi_wr_arb_2x512_wr_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst1 (
    .axi_clk  (axi_clk),
    .axi_rstn (axi_rstn),
    .inc      (aw_rdy1),
    .dec      (b_hs1),
    .at_limit (full1)
  );

endmodule

// File: tb/tb_axi_wr_arb_2x512.sv
// Directed bench for axi_wr_arb_2x512: grant order, burst length and
// wlast, outstanding limit, B routing, error flags, reset mid-burst.
module tb_axi_wr_arb_2x512;
  import axi_wr_arb_2x512_pkg::*;

  localparam int BLEN = 32;

  logic axi_clk = 1'b0;
  logic axi_rstn;
  logic err_last, err_bid;
  int   n_chk = 0;
  int   n_bad = 0;
  int   last_wait;

  axi_wr_arb_2x512_if bus();

  axi_wr_arb_2x512 #(
    .BURST_LEN (BLEN),
    .MAX_OUTST (4),
    .ID0       (6'h00),
    .ID1       (6'h08)
  ) dut (
    .axi_clk  (axi_clk),
    .axi_rstn (axi_rstn),
    .bus      (bus),
    .err_last (err_last),
    .err_bid  (err_bid)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int port, input int beat);
    logic [15:0] tagp;
    tagp = (port == 0) ? 16'hA0A0 : 16'hB1B1;
    return {16{tagp, 16'(beat)}};
  endfunction

  task automatic drive_w(input int port, input logic v, input logic [DATA_W-1:0] d, input logic l);
    if (port == 0) begin
      bus.s0_w_valid = v; bus.s0_w_data = d; bus.s0_w_last = l;
    end else begin
      bus.s1_w_valid = v; bus.s1_w_data = d; bus.s1_w_last = l;
    end
  endtask

  task automatic set_awv(input int port, input logic v);
    if (port == 0) bus.s0_aw_valid = v;
    else           bus.s1_aw_valid = v;
  endtask

  // One burst from a client: AW grant, master AW handshake, BLEN W beats.
  // wr_mode 1 toggles wready; client w_last raised at beat index last_idx;
  // abort_at >= 0 asserts reset when that beat is presented.
  task automatic run_burst(input int port, input logic drop, input int wr_mode,
                           input int last_idx, input int abort_at, input logic [31:0] addr);
    bit got;
    bit hs;
    int waited, beats, wl_hs, wl_bad, d_bad, r_bad;
    if (port == 0) bus.s0_aw_addr = addr;
    else           bus.s1_aw_addr = addr;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge axi_clk);
      if (i == 0) chk_eq("idle_wvalid", 64'(bus.wvalid), 64'd0);
      if (port == 0 ? bus.s0_aw_ready : bus.s1_aw_ready) got = 1'b1;
      else begin
        waited++;
        @(posedge axi_clk); #1;
      end
    end
    last_wait = waited;
    chk_eq("aw_grant", 64'(got), 64'd1);
    if (!got) return;
    chk_eq("aw_other_ready", 64'(port == 0 ? bus.s1_aw_ready : bus.s0_aw_ready), 64'd0);
    chk_eq("awvalid_at_T", 64'(bus.awvalid), 64'd0);
    @(posedge axi_clk); #1;
    if (drop) set_awv(port, 1'b0);
    @(negedge axi_clk);
    chk_eq("awvalid_T1", 64'(bus.awvalid), 64'd1);
    chk_eq("awid", 64'(bus.awid), 64'(port == 0 ? 6'h00 : 6'h08));
    chk_eq("awaddr", 64'(bus.awaddr), 64'({1'b0, addr}));
    chk_eq("aw_ready_pulse", 64'(port == 0 ? bus.s0_aw_ready : bus.s1_aw_ready), 64'd0);
    @(posedge axi_clk); #1;
    bus.awready = 1'b1;
    @(negedge axi_clk);
    chk_eq("awvalid_hold", 64'(bus.awvalid), 64'd1);
    chk_eq("wvalid_in_addr", 64'(bus.wvalid), 64'd0);
    @(posedge axi_clk); #1;
    bus.awready = 1'b0;
    beats = 0; wl_hs = 0; wl_bad = 0; d_bad = 0; r_bad = 0;
    drive_w(port, 1'b1, pat(port, 0), (last_idx == 0));
    for (int c = 0; c < 8 * BLEN && beats < BLEN; c++) begin
      bus.wready = (wr_mode == 0) || (c % 2 == 0);
      if (beats == abort_at) begin
        axi_rstn = 1'b0;
        #1;
        chk_eq("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk_eq("rst_wvalid", 64'(bus.wvalid), 64'd0);
        chk_eq("rst_wlast", 64'(bus.wlast), 64'd0);
        chk_eq("rst_s_w_ready", 64'(port == 0 ? bus.s0_w_ready : bus.s1_w_ready), 64'd0);
        drive_w(port, 1'b0, '0, 1'b0);
        bus.wready = 1'b0;
        return;
      end
      @(negedge axi_clk);
      hs = bus.wvalid && bus.wready;
      if (!bus.wvalid) r_bad++;
      if ((port == 0 ? bus.s0_w_ready : bus.s1_w_ready) !== bus.wready) r_bad++;
      if ((port == 0 ? bus.s1_w_ready : bus.s0_w_ready) !== 1'b0) r_bad++;
      if (hs) begin
        if (bus.wdata !== pat(port, beats)) d_bad++;
        if (bus.wlast) wl_hs++;
        if (bus.wlast !== (beats == BLEN - 1)) wl_bad++;
      end
      @(posedge axi_clk); #1;
      if (hs) begin
        beats++;
        drive_w(port, 1'b1, pat(port, beats), (beats == last_idx));
      end
    end
    drive_w(port, 1'b0, '0, 1'b0);
    bus.wready = 1'b0;
    chk_eq("w_beats", 64'(beats), 64'(BLEN));
    chk_eq("wlast_count", 64'(wl_hs), 64'd1);
    chk_eq("wlast_position", 64'(wl_bad), 64'd0);
    chk_eq("wdata_errors", 64'(d_bad), 64'd0);
    chk_eq("w_ready_valid_errors", 64'(r_bad), 64'd0);
  endtask

  task automatic send_b(input logic [5:0] id);
    bus.bid = id;
    bus.bvalid = 1'b1;
    bus.s0_b_ready = 1'b1;
    bus.s1_b_ready = 1'b1;
    @(negedge axi_clk);
    chk_eq("b_route0", 64'(bus.s0_b_valid), 64'(id == 6'h00));
    chk_eq("b_route1", 64'(bus.s1_b_valid), 64'(id == 6'h08));
    chk_eq("bready", 64'(bus.bready), 64'd1);
    @(posedge axi_clk); #1;
    bus.bvalid = 1'b0;
  endtask

  initial begin
    int blocked;
    axi_rstn = 1'b0;
    bus.s0_aw_valid = 1'b0; bus.s0_aw_addr = '0; bus.s0_b_ready = 1'b0;
    bus.s1_aw_valid = 1'b0; bus.s1_aw_addr = '0; bus.s1_b_ready = 1'b0;
    drive_w(0, 1'b0, '0, 1'b0);
    drive_w(1, 1'b0, '0, 1'b0);
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bid = '0; bus.bvalid = 1'b0;

    // reset state with both clients already requesting
    set_awv(0, 1'b1);
    set_awv(1, 1'b1);
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    chk_eq("rst_awvalid0", 64'(bus.awvalid), 64'd0);
    chk_eq("rst_wvalid0", 64'(bus.wvalid), 64'd0);
    chk_eq("rst_s0_aw_ready", 64'(bus.s0_aw_ready), 64'd0);
    chk_eq("rst_s1_aw_ready", 64'(bus.s1_aw_ready), 64'd0);
    chk_eq("rst_err_last", 64'(err_last), 64'd0);
    chk_eq("rst_err_bid", 64'(err_bid), 64'd0);
    chk_eq("awlen", 64'(bus.awlen), 64'd31);
    chk_eq("awsize", 64'(bus.awsize), 64'd6);
    chk_eq("awburst", 64'(bus.awburst), 64'd1);
    chk_eq("awlock", 64'(bus.awlock), 64'd0);
    chk_eq("wstrb", 64'(bus.wstrb), 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge axi_clk); #1;
    axi_rstn = 1'b1;

    // alternating grants, first burst with wready toggling
    run_burst(0, 1'b0, 1, BLEN - 1, -1, 32'h0000_1000);
    chk_eq("grant1_wait", 64'(last_wait), 64'd0);
    chk_eq("err_last_clean", 64'(err_last), 64'd0);
    run_burst(1, 1'b0, 0, BLEN - 1, -1, 32'h8000_2000);
    chk_eq("grant2_wait", 64'(last_wait), 64'd0);
    run_burst(0, 1'b1, 0, BLEN - 1, -1, 32'h0000_3000);
    chk_eq("grant3_wait", 64'(last_wait), 64'd0);
    run_burst(1, 1'b1, 0, BLEN - 1, -1, 32'hFFFF_F000);
    chk_eq("grant4_wait", 64'(last_wait), 64'd0);

    // return B for all four; first one stalled by the client
    bus.bid = 6'h00; bus.bvalid = 1'b1; bus.s0_b_ready = 1'b0; bus.s1_b_ready = 1'b1;
    @(negedge axi_clk);
    chk_eq("bstall_s0_b_valid", 64'(bus.s0_b_valid), 64'd1);
    chk_eq("bstall_s1_b_valid", 64'(bus.s1_b_valid), 64'd0);
    chk_eq("bstall_bready", 64'(bus.bready), 64'd0);
    @(posedge axi_clk); #1;
    send_b(6'h00);
    send_b(6'h00);
    send_b(6'h08);
    send_b(6'h08);

    // port 1 fills its outstanding budget
    set_awv(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_burst(1, 1'b0, 0, BLEN - 1, -1, 32'h0001_0000 + 32'(k) * 32'h800);
      chk_eq("p1_fill_wait", 64'(last_wait), 64'd0);
    end
    blocked = 0;
    repeat (6) begin
      @(negedge axi_clk);
      if (bus.s1_aw_ready) blocked++;
      @(posedge axi_clk); #1;
    end
    chk_eq("p1_blocked_at_limit", 64'(blocked), 64'd0);
    bus.bid = 6'h08; bus.bvalid = 1'b1; bus.s1_b_ready = 1'b1;
    @(negedge axi_clk);
    chk_eq("p1_b_valid", 64'(bus.s1_b_valid), 64'd1);
    chk_eq("p1_b_s0_valid", 64'(bus.s0_b_valid), 64'd0);
    chk_eq("p1_b_bready", 64'(bus.bready), 64'd1);
    chk_eq("p1_still_blocked", 64'(bus.s1_aw_ready), 64'd0);
    @(posedge axi_clk); #1;
    bus.bvalid = 1'b0;
    run_burst(1, 1'b1, 0, BLEN - 1, -1, 32'h0003_0000);
    chk_eq("p1_unblock_wait", 64'(last_wait), 64'd0);

    // unknown B id: drained, flagged, no routing, no count change
    bus.bid = 6'h05; bus.bvalid = 1'b1; bus.s0_b_ready = 1'b0; bus.s1_b_ready = 1'b0;
    set_awv(1, 1'b1);
    @(negedge axi_clk);
    chk_eq("unk_bready", 64'(bus.bready), 64'd1);
    chk_eq("unk_s0_b_valid", 64'(bus.s0_b_valid), 64'd0);
    chk_eq("unk_s1_b_valid", 64'(bus.s1_b_valid), 64'd0);
    chk_eq("unk_err_bid_before", 64'(err_bid), 64'd0);
    @(posedge axi_clk); #1;
    bus.bvalid = 1'b0;
    bus.bid = 6'h00;
    @(negedge axi_clk);
    chk_eq("unk_err_bid", 64'(err_bid), 64'd1);
    chk_eq("unk_p1_still_full", 64'(bus.s1_aw_ready), 64'd0);
    @(posedge axi_clk); #1;
    set_awv(1, 1'b0);

    // early client w_last on beat 10
    chk_eq("err_last_before", 64'(err_last), 64'd0);
    set_awv(0, 1'b1);
    run_burst(0, 1'b1, 0, 9, -1, 32'h0004_0000);
    chk_eq("err_last_early", 64'(err_last), 64'd1);

    // reset during beat 15 of a port 0 burst
    set_awv(0, 1'b1);
    run_burst(0, 1'b1, 0, BLEN - 1, 14, 32'h0005_0000);
    set_awv(0, 1'b1);
    set_awv(1, 1'b1);
    @(negedge axi_clk);
    chk_eq("mid_rst_s0_aw_ready", 64'(bus.s0_aw_ready), 64'd0);
    chk_eq("mid_rst_s1_aw_ready", 64'(bus.s1_aw_ready), 64'd0);
    chk_eq("mid_rst_err_last", 64'(err_last), 64'd0);
    chk_eq("mid_rst_err_bid", 64'(err_bid), 64'd0);
    @(posedge axi_clk); #1;
    axi_rstn = 1'b1;
    @(negedge axi_clk);
    chk_eq("post_rst_grant_p0", 64'(bus.s0_aw_ready), 64'd1);
    chk_eq("post_rst_no_p1", 64'(bus.s1_aw_ready), 64'd0);
    chk_eq("post_rst_awvalid", 64'(bus.awvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_arb_2x512.md
AXI_WR_ARB_2X512 -- requirements
Module: axi_wr_arb_2x512

Interface
REQ-001 Parameter BURST_LEN, default 32: W beats per burst; awlen = BURST_LEN-1.
REQ-002 Parameter MAX_OUTST, default 4: maximum un-responded bursts per slave port (1..15).
REQ-003 Parameter ID0 / ID1, default 6'h00 / 6'h08: AXI ID driven for port 0 / port 1 bursts.
REQ-004 axi_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 axi_rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 s<n>_aw_valid / s<n>_aw_ready  in/out  1  per-port (n=0,1) address request / accept.
REQ-007 s<n>_aw_addr  in  32  per-port burst start address.
REQ-008 s<n>_w_valid, s<n>_w_last / s<n>_w_ready  in / out  1  per-port write beat handshake.
REQ-009 s<n>_w_data  in  512  per-port beat data.
REQ-010 s<n>_b_valid / s<n>_b_ready  out/in  1  per-port write response.
REQ-011 awid 6, awaddr 33, awvalid 1  out; awready 1  in: master AW channel; awaddr[32]=0.
REQ-012 awlen 8, awsize 3, awburst 2, awlock 1  out: constants BURST_LEN-1, 3'b110, 2'b01, 0.
REQ-013 wdata 512, wstrb 64, wlast 1, wvalid 1  out; wready 1  in: master W channel; wstrb all-ones.
REQ-014 bid 6, bvalid 1  in; bready 1  out: master B channel.
REQ-015 err_last  out  1  sticky: slave w_last disagreed with beat count.
REQ-016 err_bid  out  1  sticky: bvalid with bid matching neither ID0 nor ID1.

Function
REQ-017 FSM states IDLE, ADDR, DATA; exactly one burst in AW/W at a time.
REQ-018 Port n eligible when s<n>_aw_valid=1 and outst<n> < MAX_OUTST.
REQ-019 IDLE: if any port eligible, grant by round-robin (prio port first, else other), pulse s<g>_aw_ready one cycle, register address, go ADDR.
REQ-020 ADDR: awvalid=1, awaddr={1'b0,reg addr}, awid=ID of grant; on awready go DATA; awvalid never drops before awready.
REQ-021 DATA: wvalid=s<g>_w_valid, wdata=s<g>_w_data, s<g>_w_ready=wready; non-granted w_ready=0.
REQ-022 Beat counter (width clog2(BURST_LEN)) counts W handshakes; wlast=1 when count=BURST_LEN-1, independent of slave w_last.
REQ-023 Last-beat handshake: counter clears, prio set to the other port, go IDLE; next grant earliest one cycle later.
REQ-024 On any W handshake where s<g>_w_last != (count==BURST_LEN-1), set err_last; burst still ends at BURST_LEN beats.
REQ-025 outst<n> increments on s<n>_aw_ready pulse, decrements on B handshake routed to port n; both same cycle: unchanged.
REQ-026 B routing: bid==ID0 -> port 0, bid==ID1 -> port 1; s<n>_b_valid=bvalid for that port; bready=s<n>_b_ready; fully combinational, independent of FSM.
REQ-027 Unknown bid: bready=1 (response consumed), err_bid set, no counter change.
REQ-028 AW/W latency: s_aw_ready pulse at cycle T, awvalid at T+1; first wvalid possible at cycle after awready.

Reset
REQ-029 axi_rstn low: state IDLE, counters/outst zero, prio port 0, err_last=err_bid=0, awvalid=wvalid=0, all s_aw_ready/s_w_ready=0.
REQ-030 Reset mid-burst abandons the burst; no completion of partial W data; outstanding counts lost.

Structure
REQ-031 Shared package holds FSM state encoding, AXI constants (size 3'b110, burst INCR) and default IDs.
REQ-032 Single module; one sub-module natural: wr_outst_cnt (per-port up/down saturating-at-limit counter), instantiated twice.

Verification
REQ-033 Both ports request at reset release -> port 0 granted first (awid 6'h00), port 1 next (awid 6'h08), alternating thereafter.
REQ-034 Port 0 burst, wready toggling 1/0 -> exactly 32 W handshakes, wlast only on 32nd, err_last=0.
REQ-035 Port 1 issues 4 bursts, no B returned -> 5th aw_valid not accepted until a bid=6'h08 B handshake occurs.
REQ-036 Port 0 drives w_last on beat 10 -> err_last=1, burst still runs 32 beats.
REQ-037 bvalid with bid=6'h05 -> bready=1 same cycle, err_bid=1, neither s_b_valid asserted.
REQ-038 axi_rstn low during DATA beat 15 -> awvalid=wvalid=0 immediately, FSM IDLE, prio port 0.
